mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority arbiter sharing one single-port memory between fetch and data ports.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_ready/if_stall        fetch port
//   d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_ready/d_stall   data port (priority)
//   m_req/m_we/m_be/m_addr/m_wdata <- m_rdata/m_ack     shared memory port
//   err                                sticky access-timeout flag
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;
  state_t state, state_n;
  logic [7:0] wcnt;
  logic busy, timeout, fin;
  logic [31:0] rdata_n;
  assign busy = (state == DATA) || (state == FETCH);
  // the abort fires on the edge where the wait count would reach TIMEOUT_CYC; an ack on that edge wins
  assign timeout = busy && !m_ack && (wcnt == 8'(TIMEOUT_CYC - 1));
  assign fin = busy && (m_ack || timeout);
  assign rdata_n = m_ack ? m_rdata : 32'hDEADBEEF;
  assign if_stall = if_req & ~if_ready;
  assign d_stall = d_req & ~d_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = d_req ? DATA : (if_req ? FETCH : IDLE);
      DONE:    state_n = IDLE;
      default: state_n = fin ? DONE : state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= 4'h0;
      m_addr   <= 32'h0;
      m_wdata  <= 32'h0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      wcnt     <= 8'h0;
    end else begin
      state    <= state_n;
      if_ready <= fin && (state == FETCH);
      d_ready  <= fin && (state == DATA);
      if (state == IDLE && (d_req || if_req)) begin
        m_req   <= 1'b1;
        m_we    <= d_req & d_we;
        m_be    <= d_req ? d_be : 4'hF;
        m_addr  <= d_req ? d_addr : if_addr;
        m_wdata <= d_req ? d_wdata : 32'h0;
        wcnt    <= 8'h0;
      end else if (busy && !m_ack) begin
        wcnt <= wcnt + 8'h1;
      end
      if (fin) m_req <= 1'b0;
      if (fin && state == FETCH) if_rdata <= rdata_n;
      // m_we holds the latched d_we, so a store never touches d_rdata
      if (fin && state == DATA && !m_we) d_rdata <= rdata_n;
      if (timeout) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (default timeout and TIMEOUT_CYC=3).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, m_ack;
  logic [3:0]  d_be;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_ready, if_stall, d_ready, d_stall, m_req, m_we, err;
  logic [3:0]  m_be;
  logic        t_if_req, t_d_req, t_ack;
  logic [31:0] t_if_rdata, t_d_rdata, t_m_addr, t_m_wdata;
  logic        t_if_ready, t_if_stall, t_d_ready, t_d_stall, t_m_req, t_m_we, t_err;
  logic [3:0]  t_m_be;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_port_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );
  mem_port_arbiter #(.TIMEOUT_CYC(3)) u_t3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(t_if_req), .if_addr(if_addr), .if_rdata(t_if_rdata), .if_ready(t_if_ready), .if_stall(t_if_stall),
    .d_req(t_d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(t_d_rdata), .d_ready(t_d_ready), .d_stall(t_d_stall),
    .m_req(t_m_req), .m_we(t_m_we), .m_be(t_m_be), .m_addr(t_m_addr), .m_wdata(t_m_wdata),
    .m_rdata(m_rdata), .m_ack(t_ack), .err(t_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  initial begin
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; m_ack = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    t_if_req = 0; t_d_req = 0; t_ack = 0;
    tick(); tick();
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_be", 32'(m_be), 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'({if_ready, d_ready}), 0);
    rst_n = 1'b1;
    tick();
    // fetch with ack in first memory cycle
    if_req = 1; if_addr = 32'h00003000;
    #1 chk("f_stall_T", 32'(if_stall), 1);
    tick();
    chk("f_m_req", 32'(m_req), 1);
    chk("f_m_addr", m_addr, 32'h00003000);
    chk("f_m_be", 32'(m_be), 32'hF);
    chk("f_m_we", 32'(m_we), 0);
    chk("f_m_wdata", m_wdata, 0);
    chk("f_stall_T1", 32'(if_stall), 1);
    m_ack = 1; m_rdata = 32'h20080005;
    tick();
    chk("f_ready", 32'(if_ready), 1);
    chk("f_rdata", if_rdata, 32'h20080005);
    chk("f_stall_T2", 32'(if_stall), 0);
    chk("f_m_req_drop", 32'(m_req), 0);
    m_ack = 0; if_req = 0;
    tick();
    chk("f_ready_pulse", 32'(if_ready), 0);
    // simultaneous requests: store wins, fetch follows
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h10; d_wdata = 32'hAABBCCDD;
    if_req = 1; if_addr = 32'h00004000;
    tick();
    chk("s_m_we", 32'(m_we), 1);
    chk("s_m_be", 32'(m_be), 32'h3);
    chk("s_m_addr", m_addr, 32'h10);
    chk("s_m_wdata", m_wdata, 32'hAABBCCDD);
    chk("s_if_stall1", 32'(if_stall), 1);
    m_ack = 1; m_rdata = 32'h55555555;
    tick();
    chk("s_d_ready", 32'(d_ready), 1);
    chk("s_if_ready", 32'(if_ready), 0);
    chk("s_d_rdata_kept", d_rdata, 0);
    chk("s_if_stall2", 32'(if_stall), 1);
    m_ack = 0; d_req = 0; d_we = 0;
    tick();
    chk("s_idle_m_req", 32'(m_req), 0);
    chk("s_if_stall3", 32'(if_stall), 1);
    tick();
    chk("s_f_m_req", 32'(m_req), 1);
    chk("s_f_m_addr", m_addr, 32'h00004000);
    chk("s_f_m_be", 32'(m_be), 32'hF);
    chk("s_f_m_we", 32'(m_we), 0);
    // requester drops mid-access; access must still complete
    if_req = 0;
    tick();
    chk("s_f_hold", 32'(m_req), 1);
    m_ack = 1; m_rdata = 32'hCAFEF00D;
    tick();
    chk("s_f_ready", 32'(if_ready), 1);
    chk("s_f_rdata", if_rdata, 32'hCAFEF00D);
    m_ack = 0;
    tick();
    // load with four wait cycles
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h20;
    tick();
    chk("l_m_req1", 32'(m_req), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l_m_req_hold", 32'(m_req), 1);
      chk("l_m_addr_hold", m_addr, 32'h20);
      chk("l_no_ready", 32'(d_ready), 0);
    end
    m_ack = 1; m_rdata = 32'h12345678;
    tick();
    chk("l_ready", 32'(d_ready), 1);
    chk("l_rdata", d_rdata, 32'h12345678);
    chk("l_err", 32'(err), 0);
    m_ack = 0; d_req = 0;
    tick();
    chk("l_ready_pulse", 32'(d_ready), 0);
    // reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h11112222;
    tick();
    chk("r_m_req", 32'(m_req), 1);
    rst_n = 0; d_req = 0; d_we = 0;
    tick();
    chk("r_m_req0", 32'(m_req), 0);
    chk("r_m_addr0", m_addr, 0);
    chk("r_m_wdata0", m_wdata, 0);
    chk("r_d_rdata0", d_rdata, 0);
    rst_n = 1; m_ack = 1;
    tick();
    chk("r_no_ready", 32'(d_ready), 0);
    chk("r_idle", 32'(m_req), 0);
    m_ack = 0;
    tick();
    chk("r_no_ready2", 32'(d_ready), 0);
    // timeout instance: fetch without ack aborts after three wait cycles
    t_if_req = 1; if_addr = 32'h00005000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t_m_req_hold", 32'(t_m_req), 1);
    end
    tick();
    chk("t_m_req_drop", 32'(t_m_req), 0);
    chk("t_if_ready", 32'(t_if_ready), 1);
    chk("t_if_rdata", t_if_rdata, 32'hDEADBEEF);
    chk("t_err", 32'(t_err), 1);
    t_if_req = 0;
    tick();
    chk("t_ready_pulse", 32'(t_if_ready), 0);
    // ack coinciding with the timeout edge completes normally
    t_d_req = 1; d_we = 0; d_addr = 32'h8;
    tick(); tick(); tick();
    chk("t2_m_req", 32'(t_m_req), 1);
    t_ack = 1; m_rdata = 32'h0BADF00D;
    tick();
    chk("t2_ready", 32'(t_d_ready), 1);
    chk("t2_rdata", t_d_rdata, 32'h0BADF00D);
    chk("t2_err_sticky", 32'(t_err), 1);
    t_ack = 0; t_d_req = 0;
    tick();
    chk("t2_ready_pulse", 32'(t_d_ready), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
